// File: rtl/psum_collector.sv
// South-edge psum collector: per-column FIFOs re-aligned into full rows.
// Optional build macro PSUM_COLLECTOR_RELU_EN clamps negative lanes to zero on pop.
module psum_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_ovf,
    output logic [psum_bw*col-1:0] out
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;

    typedef logic [AW:0]        ptr_t;
    typedef logic [psum_bw-1:0] lane_t;

    lane_t mem_q [col][depth];

    ptr_t wp_q [col];
    ptr_t wp_d [col];
    ptr_t rp_q [col];
    ptr_t rp_d [col];

    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   ovf_q, ovf_d;

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] wr_ok;
    logic           pop;

    function automatic lane_t clamp(input lane_t v);
`ifdef PSUM_COLLECTOR_RELU_EN
        return v[psum_bw-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < col; i++) begin
            empty[i] = (wp_q[i] == rp_q[i]);
            full[i]  = (wp_q[i][AW-1:0] == rp_q[i][AW-1:0]) &&
                       (wp_q[i][AW] != rp_q[i][AW]);
        end
    end

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;
    assign wr_ok   = wr & ~full;

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q | (|(wr & full));
        for (int i = 0; i < col; i++) begin
            wp_d[i] = wp_q[i] + {{AW{1'b0}}, wr_ok[i]};
            rp_d[i] = rp_q[i] + {{AW{1'b0}}, pop};
            if (pop) begin
                out_d[i*psum_bw +: psum_bw] =
                    clamp(mem_q[i][rp_q[i][AW-1:0]]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) begin
                wp_q[i] <= '0;
                rp_q[i] <= '0;
            end
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                wp_q[i] <= wp_d[i];
                rp_q[i] <= rp_d[i];
            end
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage is never cleared; only pointers define occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (reset && wr_ok[i]) begin
                mem_q[i][wp_q[i][AW-1:0]] <= in[i*psum_bw +: psum_bw];
            end
        end
    end

    assign out   = out_q;
    assign o_ovf = ovf_q;

endmodule

// File: tb/tb_psum_collector.sv
// Randomized scoreboard bench for psum_collector against a queue-based lane model.
module tb_psum_collector;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int W     = BW * COL;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   in_s = '0;
    logic [COL-1:0] wr_s = '0;
    logic           rd_s = 1'b0;
    logic           o_valid, o_ready, o_full, o_ovf;
    logic [W-1:0]   out;

    psum_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(in_s), .wr(wr_s), .rd(rd_s),
        .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full),
        .o_ovf(o_ovf), .out(out)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] lane_q [COL][$];
    logic [W-1:0]  sb [$];
    logic [W-1:0]  mdl_out;
    logic          mdl_ovf;
    int            tests = 0;
    int            fails = 0;

    function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef PSUM_COLLECTOR_RELU_EN
        return v[BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic bit mdl_valid();
        for (int i = 0; i < COL; i++)
            if (lane_q[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit mdl_full();
        for (int i = 0; i < COL; i++)
            if (lane_q[i].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic [COL-1:0] w,
                        input logic [W-1:0] d, input logic r);
        bit           ne;
        bit [COL-1:0] fl;
        logic [W-1:0] row;
        @(negedge clk);
        reset = rn; wr_s = w; in_s = d; rd_s = r;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < COL; i++) lane_q[i].delete();
            sb.delete();
            mdl_ovf = 1'b0;
            mdl_out = '0;
        end else begin
            ne = mdl_valid();
            for (int i = 0; i < COL; i++) fl[i] = (lane_q[i].size() == DEPTH);
            if (r && ne) begin
                for (int i = 0; i < COL; i++)
                    row[i*BW +: BW] = relu(lane_q[i].pop_front());
                sb.push_back(row);
                mdl_out = row;
            end
            for (int i = 0; i < COL; i++) begin
                if (w[i]) begin
                    if (fl[i]) mdl_ovf = 1'b1;
                    else lane_q[i].push_back(d[i*BW +: BW]);
                end
            end
        end
        #2;
        check("status", W'({o_valid, o_full, o_ready, o_ovf}),
              W'({mdl_valid(), mdl_full(), !mdl_full(), mdl_ovf}));
        check("out_hold", out, mdl_out);
    endtask

    task automatic do_reset();
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: every real pop must match the next scoreboard row.
    always @(posedge clk) begin
        bit fire;
        fire = rd_s && o_valid && reset;
        #1;
        if (fire) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected actual=%h expected=none", out);
            end else begin
                check("pop_row", out, sb.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        logic [BW-1:0] e0;

        do_reset();
        step(1'b1, '0, '0, 1'b0);
        check("reset_out", out, '0);
        check("reset_flags", W'({o_valid, o_ready, o_full, o_ovf}), W'(4'b0100));

        for (int i = 0; i < COL; i++) begin
            d = rand_row();
            d[i*BW +: BW] = BW'(16'h0010 + i);
            step(1'b1, COL'(1) << i, d, 1'b0);
        end
        step(1'b1, '0, '0, 1'b1);
        check("skew_row", out, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
        check("skew_valid_low", W'(o_valid), '0);

        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            d = rand_row();
            d[BW-1:0] = BW'(k);
            step(1'b1, 8'h01, d, 1'b0);
        end
        check("full_flags", W'({o_full, o_ready}), W'(2'b10));
        d = rand_row();
        d[BW-1:0] = 16'hBEEF;
        step(1'b1, 8'h01, d, 1'b0);
        check("ovf_set", W'(o_ovf), W'(1));
        for (int k = 0; k < DEPTH; k++) step(1'b1, 8'hFE, rand_row(), 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, '0, '0, 1'b1);
            check("no_beef", W'(out[BW-1:0] == 16'hBEEF), '0);
        end

        do_reset();
        step(1'b1, 8'hFF, rand_row(), 1'b0);
        step(1'b1, 8'hFF, rand_row(), 1'b1);
        check("wrpop_valid_ovf", W'({o_valid, o_ovf}), W'(2'b10));

        do_reset();
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < COL; i++) d[i*BW +: BW] = BW'(k);
            step(1'b1, 8'hFF, d, mdl_valid());
        end
        for (int k = 0; k < 20 && mdl_valid(); k++) step(1'b1, '0, '0, 1'b1);
        check("wrap_drained", W'(o_valid), '0);
        check("wrap_no_ovf", W'(o_ovf), '0);

        for (int k = 0; k < 3; k++) step(1'b1, 8'hFF, rand_row(), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        check("midrst", W'({o_valid, out}), '0);
        d = '0;
        d[BW-1:0]   = 16'hFFFF;
        d[2*BW-1:BW] = 16'h0005;
        step(1'b1, 8'hFF, d, 1'b0);
        step(1'b1, '0, '0, 1'b1);
`ifdef PSUM_COLLECTOR_RELU_EN
        e0 = 16'h0000;
`else
        e0 = 16'hFFFF;
`endif
        check("relu_lane0", W'(out[BW-1:0]), W'(e0));
        check("relu_lane1", W'(out[2*BW-1:BW]), W'(16'h0005));

        do_reset();
        for (int k = 0; k < 400; k++)
            step(1'b1, COL'($urandom), rand_row(), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 2 * DEPTH && mdl_valid(); k++)
            step(1'b1, '0, '0, 1'b1);
        step(1'b1, '0, '0, 1'b0);
        check("sb_empty", W'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
